// File: rtl/cmd_enc.sv
// cmd_enc: UART command-frame transmitter (8N1, LSB first).
// On an accepted SEND it serializes HEADER, TX_CMD, TX_DAT, CHK
// (CHK = HEADER ^ TX_CMD ^ TX_DAT) onto IF_TX, every bit lasting
// BIT_PERIOD clocks, with GAP_BITS idle-high bit periods after each stop bit.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous, active-low reset
//   SEND    in   one-cycle frame request, sampled only while idle
//   TX_CMD  in   command byte, latched on SEND acceptance
//   TX_DAT  in   data byte, latched on SEND acceptance
//   IF_TX   out  serial line, idle high, driven straight from a flop
//   BUSY    out  high from SEND acceptance until the frame ends
//   DONE    out  one-cycle pulse at the end of the frame
`timescale 1ns/1ps
module cmd_enc #(
  parameter int         BIT_PERIOD = 174,
  parameter logic [7:0] HEADER     = 8'h55,
  parameter int         GAP_BITS   = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND,
  input  logic [7:0] TX_CMD,
  input  logic [7:0] TX_DAT,
  output logic       IF_TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [11:0] BIT_LAST = 12'(BIT_PERIOD - 1);
  localparam logic [3:0]  GAP_LAST = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  // The "next byte" decision is taken on the last cycle of the final stop/gap
  // bit rather than in a state of its own, so consecutive bytes abut with no
  // extra idle clock and the frame length stays an exact multiple of bits.
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  dat_q, dat_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  cur_byte;
  logic [2:0]  bit_nx;
  logic        bit_end;
  logic        byte_end;

  always_comb begin
    cur_byte = HEADER;
    case (idx_q)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = cmd_q;
      2'd2:    cur_byte = dat_q;
      default: cur_byte = HEADER ^ cmd_q ^ dat_q;
    endcase
  end

  assign bit_nx  = bit_q + 3'd1;
  assign bit_end = (baud_q == BIT_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    byte_end = 1'b0;

    // Baud counter free-runs while a frame is active and reloads every bit.
    if (state_q != S_IDLE) baud_d = bit_end ? 12'd0 : baud_q + 12'd1;
    else                   baud_d = 12'd0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (SEND) begin
          state_d = S_START;
          cmd_d   = TX_CMD;
          dat_d   = TX_DAT;
          idx_d   = 2'd0;
          bit_d   = 3'd0;
          gap_d   = 4'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur_byte[bit_nx];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (GAP_BITS == 0) byte_end = 1'b1;
          else begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) byte_end = 1'b1;
          else                   gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_end) begin
      if (idx_q != 2'd3) begin
        idx_d   = idx_q + 2'd1;
        state_d = S_START;
        tx_d    = 1'b0;
      end else begin
        idx_d   = 2'd0;
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      bit_d = 3'd0;
      gap_d = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      baud_q  <= 12'd0;
      bit_q   <= 3'd0;
      idx_q   <= 2'd0;
      gap_q   <= 4'd0;
      cmd_q   <= 8'd0;
      dat_q   <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign IF_TX = tx_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_cmd_enc.sv
// Bench for cmd_enc: two instances (default 174-clock bits with no gap, and
// 10-clock bits with two gap bits) share the same random stimulus. A
// frame-level reference model predicts line/BUSY/DONE from the acceptance
// cycle and pushes expected bytes into a per-instance queue; a UART monitor
// decodes each line independently and pops/compares the bytes.
`timescale 1ns/1ps
module tb_cmd_enc;
  localparam int BP0 = 174, G0 = 0;
  localparam int BP1 = 10,  G1 = 2;
  localparam logic [7:0] HDR = 8'h55;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEND = 1'b0;
  logic [7:0] TX_CMD = 8'h00;
  logic [7:0] TX_DAT = 8'h00;
  logic [1:0] tx, busy, done;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  finish_req = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  cmd_enc #(.BIT_PERIOD(BP0), .HEADER(HDR), .GAP_BITS(G0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .SEND(SEND), .TX_CMD(TX_CMD), .TX_DAT(TX_DAT),
    .IF_TX(tx[0]), .BUSY(busy[0]), .DONE(done[0]));

  cmd_enc #(.BIT_PERIOD(BP1), .HEADER(HDR), .GAP_BITS(G1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .SEND(SEND), .TX_CMD(TX_CMD), .TX_DAT(TX_DAT),
    .IF_TX(tx[1]), .BUSY(busy[1]), .DONE(done[1]));

  function automatic int bp_of(int g);
    return (g == 0) ? BP0 : BP1;
  endfunction
  function automatic int gap_of(int g);
    return (g == 0) ? G0 : G1;
  endfunction

  // Reference model and scoreboard state
  bit         active [2];
  int         kst    [2];
  logic [7:0] fb     [2][4];
  logic [7:0] exp_q  [2][$];
  bit         mon_on [2];
  int         mon_t0 [2];
  logic [7:0] mon_val[2];

  task automatic check(input string nm, input int g, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
      if (fails >= 200) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  // Checker: model prediction, UART monitor, acceptance tracking
  always @(negedge CLK) begin
    int F, bl, t, by, pos, d, expv;
    logic [2:0] e;
    logic line;
    for (int g = 0; g < 2; g++) begin
      F  = 4 * (10 + gap_of(g)) * bp_of(g);
      bl = (10 + gap_of(g)) * bp_of(g);
      // Expected {IF_TX, BUSY, DONE} this cycle
      if (!RESET) begin
        e = 3'b100;
        active[g] = 1'b0;
        exp_q[g].delete();
        mon_on[g] = 1'b0;
      end else if (active[g] && (cyc - kst[g]) < F) begin
        t   = cyc - kst[g];
        by  = t / bl;
        pos = (t % bl) / bp_of(g);
        if (pos == 0)      line = 1'b0;
        else if (pos <= 8) line = fb[g][by][pos-1];
        else               line = 1'b1;
        e = {line, 2'b10};
      end else if (active[g] && (cyc - kst[g]) == F) begin
        e = 3'b101;
      end else begin
        e = 3'b100;
      end
      check("line_busy_done", g, int'({tx[g], busy[g], done[g]}), int'(e));

      // UART monitor: mid-bit sampling relative to the observed falling edge
      if (RESET) begin
        if (!mon_on[g] && tx[g] == 1'b0) begin
          mon_on[g] = 1'b1;
          mon_t0[g] = cyc;
          mon_val[g] = 8'h00;
        end else if (mon_on[g]) begin
          d = cyc - mon_t0[g];
          for (int i = 1; i <= 8; i++)
            if (d == bp_of(g)/2 + i*bp_of(g)) mon_val[g][i-1] = tx[g];
          if (d == bp_of(g)/2 + 9*bp_of(g)) begin
            check("stop_bit", g, int'(tx[g]), 1);
            expv = (exp_q[g].size() > 0) ? int'(exp_q[g].pop_front()) : 'h100;
            check("rx_byte", g, int'(mon_val[g]), expv);
            mon_on[g] = 1'b0;
          end
        end
      end

      // Acceptance at the next rising edge
      if (RESET && SEND && (!active[g] || (cyc + 1 - kst[g]) > F)) begin
        active[g] = 1'b1;
        kst[g]    = cyc + 1;
        fb[g][0]  = HDR;
        fb[g][1]  = TX_CMD;
        fb[g][2]  = TX_DAT;
        fb[g][3]  = HDR ^ TX_CMD ^ TX_DAT;
        for (int b = 0; b < 4; b++) exp_q[g].push_back(fb[g][b]);
      end
    end

    if (finish_req) begin
      for (int g = 0; g < 2; g++) check("queue_drained", g, exp_q[g].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic pulse_send(input logic [7:0] c, input logic [7:0] dd);
    TX_CMD = c;
    TX_DAT = dd;
    SEND   = 1'b1;
    tick(1);
    SEND   = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    tick(3);
    RESET = 1'b1;
    tick(2);

    // Frame 31/80 with ignored mid-frame requests and operand changes
    pulse_send(8'h31, 8'h80);
    tick(98);
    pulse_send(8'h99, 8'h80);
    tick(2899);
    pulse_send(8'h99, 8'h11);
    tick(4100);

    // Reset ~2000 cycles into a frame, then a clean frame afterwards
    pulse_send(8'h32, 8'h00);
    tick(1999);
    RESET = 1'b0;
    tick(3);
    RESET = 1'b1;
    tick(1);
    pulse_send(8'h30, 8'h05);
    tick(7000);

    // Random requests with operands changing every cycle
    for (int i = 0; i < 21000; i++) begin
      SEND   = ($urandom_range(0, 499) == 0);
      TX_CMD = 8'($urandom);
      TX_DAT = 8'($urandom);
      tick(1);
    end
    SEND = 1'b0;
    tick(7000);

    // SEND held high: back-to-back frames
    TX_CMD = 8'hA5;
    TX_DAT = 8'h3C;
    SEND   = 1'b1;
    tick(14500);
    SEND   = 1'b0;
    tick(7000);

    finish_req = 1'b1;
    tick(5);
    $display("FAIL timeout: checker did not finish");
    $fatal(1);
  end
endmodule
